eb_rx_lock_ctrl: RTL and testbench

//  Write-side sequencer for the elastic buffer, in the recovered-clock (cdr_clk) domain.

---
 rtl/eb_rx_lock_ctrl_pkg.sv | 18 +
 rtl/eb_rx_lock_ctrl_if.sv | 22 ++
 rtl/eb_rx_lock_ctrl_sat_cnt.sv | 27 ++
 rtl/eb_rx_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_eb_rx_lock_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eb_rx_lock_ctrl_pkg.sv
// Shared types and helpers for the elastic-buffer write-side lock controller.
package eb_pkg;

  typedef enum logic [1:0] {
    EB_IDLE   = 2'b00,
    EB_HUNT   = 2'b01,
    EB_LOCKED = 2'b10
  } eb_lock_state_t;

  localparam int EB_DATA_W = 20;

  function automatic logic is_skp(input logic [EB_DATA_W-1:0] word,
                                  input logic [EB_DATA_W-1:0] seq1,
                                  input logic [EB_DATA_W-1:0] seq2);
    return (word == seq1) || (word == seq2);
  endfunction

endpackage

// File: rtl/eb_rx_lock_ctrl_if.sv
// Decoder-to-elastic-buffer word stream passing through the lock controller.
interface eb_rx_lock_ctrl_if #(
  parameter int DATA_WIDTH = 20
) ();

  logic [DATA_WIDTH-1:0] rx_data_i;
  logic                  rx_vld_i;
  logic                  rx_dec_err_i;
  logic [DATA_WIDTH-1:0] eb_data_o;
  logic                  eb_wr_vld_o;

  modport master (
    output rx_data_i, rx_vld_i, rx_dec_err_i,
    input  eb_data_o, eb_wr_vld_o
  );

  modport slave (
    input  rx_data_i, rx_vld_i, rx_dec_err_i,
    output eb_data_o, eb_wr_vld_o
  );

endinterface

// File: rtl/eb_rx_lock_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; CLR_PRIO selects whether a
// same-cycle clear beats the increment (0) or restarts the count at 1.
module eb_sat_cnt #(
  parameter int W        = 8,
  parameter bit CLR_PRIO = 1'b1
) (
  input  logic         cdr_clk_i,
  input  logic         sys_arst_n_i,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_q_inc;

  assign w_q_inc = (&r_q) ? r_q : r_q + 1'b1;
  assign o_q     = r_q;

  always_ff @(posedge cdr_clk_i or negedge sys_arst_n_i) begin
    if (!sys_arst_n_i)                   r_q <= '0;
    else if (i_clr && (CLR_PRIO || !i_inc)) r_q <= '0;
    else if (i_clr)                      r_q <= W'(1);
    else if (i_inc)                      r_q <= w_q_inc;
  end

endmodule

// File: rtl/eb_rx_lock_ctrl.sv
// Recovered-clock write sequencer: hunts for SKP lock, gates writes into the
// elastic buffer, drops lock on error bursts and polices the SKP interval.
module eb_rx_lock_ctrl
  import eb_pkg::*;
#(
  parameter int DATA_WIDTH     = EB_DATA_W,
  parameter int LOCK_CNT       = 4,
  parameter int UNLOCK_ERR_CNT = 4,
  parameter int SKPI_W         = 12
) (
  input  logic                 cdr_clk_i,
  input  logic                 sys_arst_n_i,
  input  logic                 cfg_enable_i,
  input  logic [EB_DATA_W-1:0] cfg_cor_seq_val_1_i,
  input  logic [EB_DATA_W-1:0] cfg_cor_seq_val_2_i,
  input  logic [SKPI_W-1:0]    cfg_skp_intv_max_i,
  input  logic                 stat_clear_i,
  eb_rx_lock_ctrl_if.slave     rx_eb,
  output logic                 lock_o,
  output logic [1:0]           state_o,
  output logic                 skp_seen_pulse_o,
  output logic                 skp_intv_err_o,
  output logic [7:0]           lock_loss_cnt_o
);

  localparam int SKP_W = $clog2(LOCK_CNT + 1);
  localparam int ERR_W = $clog2(UNLOCK_ERR_CNT + 1);
  localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(UNLOCK_ERR_CNT - 1);

  eb_lock_state_t        r_state, w_state_nxt;
  logic [SKP_W-1:0]      r_skp_cnt, w_skp_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_eb_data;
  logic                  r_eb_wr_vld, w_wr_vld_nxt;
  logic                  r_skp_pulse, w_pulse_nxt;
  logic                  r_intv_err, w_intv_err_set;
  logic                  w_skp;
  logic                  w_err_inc, w_err_clr, w_intv_inc, w_intv_clr, w_loss_inc;
  logic [ERR_W-1:0]      w_err_cnt;
  logic [SKPI_W-1:0]     w_intv_cnt;

  assign w_skp = rx_eb.rx_vld_i && !rx_eb.rx_dec_err_i &&
                 is_skp(rx_eb.rx_data_i, cfg_cor_seq_val_1_i, cfg_cor_seq_val_2_i);

  eb_sat_cnt #(.W(ERR_W), .CLR_PRIO(1'b1)) u_err_cnt (
    .cdr_clk_i(cdr_clk_i), .sys_arst_n_i(sys_arst_n_i),
    .i_inc(w_err_inc), .i_clr(w_err_clr), .o_q(w_err_cnt)
  );

  eb_sat_cnt #(.W(SKPI_W), .CLR_PRIO(1'b1)) u_intv_cnt (
    .cdr_clk_i(cdr_clk_i), .sys_arst_n_i(sys_arst_n_i),
    .i_inc(w_intv_inc), .i_clr(w_intv_clr), .o_q(w_intv_cnt)
  );

  // Clear loses to a same-cycle lock loss so the new event is never dropped.
  eb_sat_cnt #(.W(8), .CLR_PRIO(1'b0)) u_loss_cnt (
    .cdr_clk_i(cdr_clk_i), .sys_arst_n_i(sys_arst_n_i),
    .i_inc(w_loss_inc), .i_clr(stat_clear_i), .o_q(lock_loss_cnt_o)
  );

  always_ff @(posedge cdr_clk_i or negedge sys_arst_n_i) begin
    if (!sys_arst_n_i) begin
      r_state   <= EB_IDLE;
      r_skp_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_skp_cnt <= w_skp_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_skp_cnt_nxt  = r_skp_cnt;
    w_wr_vld_nxt   = 1'b0;
    w_pulse_nxt    = 1'b0;
    w_intv_err_set = 1'b0;
    w_err_inc      = 1'b0;
    w_err_clr      = 1'b0;
    w_intv_inc     = 1'b0;
    w_intv_clr     = 1'b0;
    w_loss_inc     = 1'b0;
    if (!cfg_enable_i) begin
      w_state_nxt = EB_IDLE;
    end else begin
      case (r_state)
        EB_IDLE: begin
          w_state_nxt   = EB_HUNT;
          w_skp_cnt_nxt = '0;
        end
        EB_HUNT: begin
          if (rx_eb.rx_vld_i) begin
            if (!w_skp) begin
              w_skp_cnt_nxt = '0;
            end else if (r_skp_cnt == SKP_LAST) begin
              w_state_nxt   = EB_LOCKED;
              w_skp_cnt_nxt = '0;
              w_wr_vld_nxt  = 1'b1;
              w_err_clr     = 1'b1;
              w_intv_clr    = 1'b1;
            end else begin
              w_skp_cnt_nxt = r_skp_cnt + 1'b1;
            end
          end
        end
        EB_LOCKED: begin
          if (rx_eb.rx_vld_i) begin
            // Errored words are non-SKP valid words and still age the interval.
            w_intv_clr     = w_skp;
            w_intv_inc     = !w_skp;
            w_intv_err_set = !w_skp && (cfg_skp_intv_max_i != '0) &&
                             (w_intv_cnt >= cfg_skp_intv_max_i);
            if (!rx_eb.rx_dec_err_i) begin
              w_wr_vld_nxt = 1'b1;
              w_pulse_nxt  = w_skp;
              w_err_clr    = 1'b1;
            end else if (w_err_cnt == ERR_LAST) begin
              w_state_nxt   = EB_HUNT;
              w_skp_cnt_nxt = '0;
              w_err_clr     = 1'b1;
              w_loss_inc    = 1'b1;
            end else begin
              w_err_inc = 1'b1;
            end
          end
        end
        default: w_state_nxt = EB_IDLE;
      endcase
    end
  end

  always_ff @(posedge cdr_clk_i or negedge sys_arst_n_i) begin
    if (!sys_arst_n_i) begin
      r_eb_data   <= '0;
      r_eb_wr_vld <= 1'b0;
      r_skp_pulse <= 1'b0;
      r_intv_err  <= 1'b0;
    end else begin
      r_eb_wr_vld <= w_wr_vld_nxt;
      r_skp_pulse <= w_pulse_nxt;
      if (w_wr_vld_nxt)        r_eb_data  <= rx_eb.rx_data_i;
      if (w_intv_err_set)      r_intv_err <= 1'b1;
      else if (stat_clear_i)   r_intv_err <= 1'b0;
    end
  end

  assign rx_eb.eb_data_o   = r_eb_data;
  assign rx_eb.eb_wr_vld_o = r_eb_wr_vld;
  assign lock_o            = (r_state == EB_LOCKED);
  assign state_o           = r_state;
  assign skp_seen_pulse_o  = r_skp_pulse;
  assign skp_intv_err_o    = r_intv_err;

endmodule

// File: tb/tb_eb_rx_lock_ctrl.sv
// Scoreboarded random/directed bench for eb_rx_lock_ctrl against a word-level behavioural model.
module tb_eb_rx_lock_ctrl;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 4;
  localparam logic [19:0] SEQ1 = 20'h5F0A3;
  localparam logic [19:0] SEQ2 = 20'hA0F5C;

  typedef struct {
    logic [1:0]  st;
    logic        lock;
    logic        wr;
    logic [19:0] data;
    logic        pulse;
    logic        ierr;
    logic [7:0]  loss;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [19:0] seq1, seq2;
  logic [11:0] intv_max;
  logic        clr;
  logic        lock;
  logic [1:0]  state;
  logic        pulse;
  logic        ierr;
  logic [7:0]  loss;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t q[$];

  // behavioural model state: mode 0=idle 1=hunt 2=locked
  int          m_mode, m_hunt_run, m_err_run, m_gap, m_loss;
  logic        m_sticky;
  logic [19:0] m_data;

  eb_rx_lock_ctrl_if #(.DATA_WIDTH(20)) bus ();

  eb_rx_lock_ctrl #(
    .DATA_WIDTH(20), .LOCK_CNT(LOCK_N), .UNLOCK_ERR_CNT(UNLOCK_N), .SKPI_W(12)
  ) dut (
    .cdr_clk_i(clk),
    .sys_arst_n_i(rst_n),
    .cfg_enable_i(en),
    .cfg_cor_seq_val_1_i(seq1),
    .cfg_cor_seq_val_2_i(seq2),
    .cfg_skp_intv_max_i(intv_max),
    .stat_clear_i(clr),
    .rx_eb(bus.slave),
    .lock_o(lock),
    .state_o(state),
    .skp_seen_pulse_o(pulse),
    .skp_intv_err_o(ierr),
    .lock_loss_cnt_o(loss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset;
    m_mode = 0; m_hunt_run = 0; m_err_run = 0; m_gap = 0; m_loss = 0;
    m_sticky = 1'b0; m_data = '0;
  endtask

  // Expected outputs after the coming clock edge, from the word-level rules.
  task automatic model_step(input logic e_n, input logic v, input logic [19:0] d,
                            input logic er, input logic c, output exp_t x);
    bit is_skp, lost, intv_bad;
    is_skp = v && !er && (d == seq1 || d == seq2);
    lost = 0; intv_bad = 0;
    x.wr = 0; x.pulse = 0;
    if (!e_n) m_mode = 0;
    else if (m_mode == 0) begin
      m_mode = 1; m_hunt_run = 0;
    end else if (m_mode == 1) begin
      if (v) begin
        m_hunt_run = is_skp ? m_hunt_run + 1 : 0;
        if (m_hunt_run == LOCK_N) begin
          m_mode = 2; m_hunt_run = 0; m_err_run = 0; m_gap = 0;
          x.wr = 1; m_data = d;
        end
      end
    end else if (v) begin
      m_gap = is_skp ? 0 : m_gap + 1;
      if (intv_max != 0 && m_gap > int'(intv_max)) intv_bad = 1;
      if (!er) begin
        x.wr = 1; m_data = d; m_err_run = 0; x.pulse = is_skp;
      end else begin
        m_err_run++;
        if (m_err_run == UNLOCK_N) begin
          m_mode = 1; m_hunt_run = 0; m_err_run = 0; lost = 1;
        end
      end
    end
    if (c) begin m_sticky = 0; m_loss = 0; end
    if (intv_bad) m_sticky = 1;
    if (lost && m_loss < 255) m_loss++;
    x.st   = (m_mode == 2) ? 2'b10 : (m_mode == 1) ? 2'b01 : 2'b00;
    x.lock = (m_mode == 2);
    x.data = m_data;
    x.ierr = m_sticky;
    x.loss = 8'(m_loss);
  endtask

  task automatic step(input logic v, input logic [19:0] d, input logic er,
                      input logic e_n = 1'b1, input logic c = 1'b0);
    exp_t x;
    bus.rx_vld_i = v; bus.rx_data_i = d; bus.rx_dec_err_i = er;
    en = e_n; clr = c;
    model_step(e_n, v, d, er, c, x);
    @(posedge clk);
    q.push_back(x);
    #1;
  endtask

  task automatic check_reset_outputs;
    chk("rst_state", 32'(state), 0);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_wr", 32'(bus.eb_wr_vld_o), 0);
    chk("rst_data", 32'(bus.eb_data_o), 0);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_ierr", 32'(ierr), 0);
    chk("rst_loss", 32'(loss), 0);
  endtask

  task automatic do_reset;
    @(negedge clk); #1;
    rst_n = 1'b0; bus.rx_vld_i = 1'b0; en = 1'b0; clr = 1'b0;
    #2;
    check_reset_outputs();
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic skps(input int n);
    for (int i = 0; i < n; i++) step(1, (i % 2) ? SEQ2 : SEQ1, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("lock", 32'(lock), 32'(e.lock));
      chk("wr_vld", 32'(bus.eb_wr_vld_o), 32'(e.wr));
      chk("data", 32'(bus.eb_data_o), 32'(e.data));
      chk("skp_pulse", 32'(pulse), 32'(e.pulse));
      chk("intv_err", 32'(ierr), 32'(e.ierr));
      chk("lock_loss", 32'(loss), 32'(e.loss));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] w;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; intv_max = '0;
    seq1 = SEQ1; seq2 = SEQ2;
    bus.rx_vld_i = 1'b0; bus.rx_data_i = '0; bus.rx_dec_err_i = 1'b0;
    model_reset();
    #12;
    check_reset_outputs();
    rst_n = 1'b1;

    // 1: lock on four SKPs, then a data word
    step(0, 0, 0);
    for (int i = 0; i < LOCK_N; i++) step(1, SEQ1, 0);
    step(1, 20'h12345, 0);
    step(0, 0, 0);

    // 2: broken SKP run in hunt
    step(0, 0, 0, 0);
    step(0, 0, 0);
    skps(3); step(1, 20'h00777, 0); step(0, 0, 0); skps(4);
    step(1, 20'h0ABCD, 0);

    // 3: error bursts in lock
    for (int i = 0; i < 3; i++) step(1, 20'h11111 * (i + 1), 1);
    step(1, 20'h0F0F0, 0);
    for (int i = 0; i < 4; i++) step(1, 20'h22222, 1);
    step(1, 20'h33333, 0);

    // 4: SKP interval policing and sticky clear
    step(0, 0, 0, 0);
    intv_max = 12'd10;
    step(0, 0, 0);
    skps(4);
    for (int i = 0; i < 11; i++) step(1, 20'h40000 + 20'(i), 0);
    step(1, SEQ2, 0);
    step(1, 20'h45678, 0);
    step(0, 0, 0, 1, 1);
    step(1, 20'h45679, 0);

    // 5: disable while locked with a valid word
    step(1, 20'h55555, 0, 0);
    step(1, 20'h55556, 0, 0);

    // 6: async reset mid-stream, then saturate the lock-loss counter
    step(1, 20'h66666, 0);
    skps(4);
    step(1, 20'h66667, 0);
    do_reset();
    intv_max = '0;
    step(0, 0, 0);
    for (int k = 0; k < 257; k++) begin
      skps(4);
      for (int i = 0; i < 4; i++) step(1, 20'h7FFFF, 1);
    end
    // clear coinciding with a lock loss
    skps(4);
    for (int i = 0; i < 3; i++) step(1, 20'h7FFFF, 1);
    step(1, 20'h7FFFF, 1, 1, 1);

    // random phase with a small interval limit
    step(0, 0, 0, 0);
    intv_max = 12'd5;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 2))
        0:       w = SEQ1;
        1:       w = SEQ2;
        default: w = 20'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) != 0), ($urandom_range(0, 49) == 0));
    end

    bus.rx_vld_i = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
